// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: WIDTH split into STAGES ripple chunks, carry registered between stages.
// Optional signed-overflow output enabled by defining PIPELINED_RIPPLE_ADDER_OVF_EN.

module pra_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);
endmodule

module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: STAGES must divide WIDTH");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] vld_pipe;

  assign b_eff     = in_sub ? ~in_b : in_b;
  assign c0        = in_sub ? 1'b1 : in_cin;
  assign out_valid = vld_pipe[STAGES-1];
  // Whole pipe moves in lockstep; bubbles are kept, not squeezed.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int IW = WIDTH - LO;   // operand bits not yet consumed

    logic [IW-1:0]       ra_i, rb_i;
    logic [CHUNK:0]      cy;
    logic [CHUNK-1:0]    cs;
    logic [LO+CHUNK-1:0] s_n, s_q;
    logic                c_q;

    if (k == 0) begin : g_head
      assign ra_i  = in_a;
      assign rb_i  = b_eff;
      assign cy[0] = c0;
      assign s_n   = cs;
    end else begin : g_tail
      assign ra_i  = g_st[k-1].g_rem.ra_q;
      assign rb_i  = g_st[k-1].g_rem.rb_q;
      assign cy[0] = g_st[k-1].c_q;
      assign s_n   = {cs, g_st[k-1].s_q};
    end

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      pra_fa u_fa (.x(ra_i[i]), .y(rb_i[i]), .z(cy[i]), .s(cs[i]), .co(cy[i+1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_n;
        c_q <= cy[CHUNK];
      end
    end

    if (IW > CHUNK) begin : g_rem
      logic [IW-CHUNK-1:0] ra_q, rb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv) begin
          ra_q <= ra_i[IW-1:CHUNK];
          rb_q <= rb_i[IW-1:CHUNK];
        end
      end
    end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    // Carry into MSB vs carry out of MSB, taken on b_eff so subtract is covered.
    if (k == STAGES-1) begin : g_ovf
      logic o_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   o_q <= 1'b0;
        else if (adv) o_q <= cy[CHUNK] ^ cy[CHUNK-1];
      end
    end
`endif
  end

  assign out_sum  = g_st[STAGES-1].s_q;
  assign out_cout = g_st[STAGES-1].c_q;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  assign out_ovf  = g_st[STAGES-1].g_ovf.o_q;
`endif

endmodule
